i2c_target: RTL

I2C target (slave) with a 256×8 register file, responding at a fixed 7-bit address to the subaddress/data write protocol the HDMI config master uses, plus combined-format reads. It sits on the same I2C_SCL/I2C_SDA pins as the master side. It serves as a loopback or peripheral-emulation endpoint, for example standing in for the ADV7513 in system simulation or exposing core registers to an external controller. A host-side port gives the core direct access to the register file and notifies it of every bus write.

---
 rtl/i2c_target.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// ============================================================================
// i2c_target : I2C target at a fixed 7-bit address with a 256x8 register file
//              and a host-side access port. Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_target #(
    parameter logic [6:0] ADDR   = 7'h39,
    parameter int         FILTER = 4
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       I2C_SCL,
    inout  wire        I2C_SDA,
    input  logic [7:0] host_addr,
    input  logic       host_we,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_SUB, ST_SUB_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RD_MACK
    } state_t;

    logic [1:0] raw, filt, filt_d;
    assign raw = {I2C_SDA, I2C_SCL};

    // Bit 0 is SCL, bit 1 is SDA; both preset high so reset looks like an idle bus
    for (genvar g = 0; g < 2; g++) begin : g_cond
        logic          s1, s2, f, fd;
        logic [CW-1:0] cnt;
        always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N) begin
                s1  <= 1'b1;
                s2  <= 1'b1;
                f   <= 1'b1;
                fd  <= 1'b1;
                cnt <= '0;
            end else begin
                s1 <= raw[g];
                s2 <= s1;
                fd <= f;
                if (s2 == f) begin
                    cnt <= '0;
                end else if (cnt == CW'(FILTER - 1)) begin
                    f   <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
        assign filt[g]   = f;
        assign filt_d[g] = fd;
    end

    logic scl_rise, scl_fall, start_det, stop_det, sda_f;
    assign sda_f     = filt[1];
    assign scl_rise  = filt[0] & ~filt_d[0];
    assign scl_fall  = ~filt[0] & filt_d[0];
    assign start_det = filt[0] & filt_d[0] & filt_d[1] & ~filt[1];
    assign stop_det  = filt[0] & filt_d[0] & ~filt_d[1] & filt[1];

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift, ptr, in_byte, rd_byte;
    logic       rw, sda_oe, i2c_we;
    logic [7:0] regs [256];

    assign in_byte = {shift[6:0], sda_f};
    assign rd_byte = regs[ptr];
    assign i2c_we  = (state == ST_WDATA) && scl_rise && (bit_cnt == 3'd7)
                     && !start_det && !stop_det;
    assign I2C_SDA = sda_oe ? 1'b0 : 1'bz;

    // Assigned after the host write so an I2C write to the same address wins
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
            host_rdata <= 8'h00;
        end else begin
            host_rdata <= regs[host_addr];
            if (host_we) regs[host_addr] <= host_wdata;
            if (i2c_we)  regs[ptr]       <= in_byte;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            ptr       <= 8'h00;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR, ST_SUB, ST_WDATA: begin
                        if (scl_rise) begin
                            shift   <= in_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == ST_ADDR) begin
                                    if (in_byte[7:1] == ADDR) begin
                                        state <= ST_ADDR_ACK;
                                        busy  <= 1'b1;
                                        rw    <= in_byte[0];
                                    end else begin
                                        state <= ST_IDLE;
                                        busy  <= 1'b0;
                                    end
                                end else if (state == ST_SUB) begin
                                    ptr   <= in_byte;
                                    state <= ST_SUB_ACK;
                                end else begin
                                    wr_strobe <= 1'b1;
                                    wr_addr   <= ptr;
                                    wr_data   <= in_byte;
                                    ptr       <= ptr + 8'd1;
                                    state     <= ST_WDATA_ACK;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
                        // First SCL fall starts the ACK, the second one ends it
                        if (scl_fall) begin
                            bit_cnt <= 3'd0;
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else if (state == ST_ADDR_ACK && rw) begin
                                shift  <= rd_byte;
                                sda_oe <= ~rd_byte[7];
                                ptr    <= ptr + 8'd1;
                                state  <= ST_RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= (state == ST_ADDR_ACK) ? ST_SUB : ST_WDATA;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe <= 1'b0;
                                state  <= ST_RD_MACK;
                            end else begin
                                shift   <= {shift[6:0], 1'b0};
                                sda_oe  <= ~shift[6];
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    ST_RD_MACK: begin
                        // A fall seen here always follows an ACK-sampling rise
                        if (scl_rise && sda_f) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else if (scl_fall) begin
                            shift   <= rd_byte;
                            sda_oe  <= ~rd_byte[7];
                            ptr     <= ptr + 8'd1;
                            bit_cnt <= 3'd0;
                            state   <= ST_RDATA;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
